// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   - uart_state_t : state encoding; names match the receiver's states.
//   - DATA_BITS, STOP_BITS : frame shape.
//   - CLKS_PER_BIT_DEFAULT : default clock cycles per serial bit.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TX_START_BIT  = 3'd1,
        TX_DATA_BITS  = 3'd2,
        TX_PARITY_BIT = 3'd3,
        TX_STOP_BIT   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-level handshake and line signals of the UART transmitter.
//   i_TX_DV     : byte-valid strobe from the producer.
//   i_TX_Byte   : byte to send.
//   o_TX_Ready  : holding register empty.
//   o_TX_Active : frame in progress.
//   o_TX_Serial : serial line, idles high.
//   o_TX_Done   : one-cycle pulse at the end of each stop bit.
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 i_TX_DV;
    logic [DATA_BITS-1:0] i_TX_Byte;
    logic                 o_TX_Ready;
    logic                 o_TX_Active;
    logic                 o_TX_Serial;
    logic                 o_TX_Done;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_TX_Active,
        input  o_TX_Serial,
        input  o_TX_Done
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_TX_Active,
        output o_TX_Serial,
        output o_TX_Done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts i_Clock cycles within one serial bit.
//   i_Clock, i_Reset : clock, asynchronous active-high reset.
//   clear            : restart the count at zero (frame start).
//   enable           : count while a frame is on the line.
//   bit_end          : high in the last cycle of each bit (count == CLKS_PER_BIT-1).
// Shared with the receiver, so it carries no transmitter-specific logic.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign bit_end = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, 1 start, 1 stop bit,
// with a one-byte holding register so frames can run back to back.
//   i_Clock : system clock, rising edge.
//   i_Reset : asynchronous active-high reset; aborts any frame in flight.
//   tx_bus  : uart_tx_if.slave (byte handshake in, serial line and status out).
// Build option: define UART_TX_PARITY_EN to add a parity bit
// (value ^byte ^ PARITY_ODD) between the last data bit and the stop bit.
//
//   state         | meaning
//   --------------+---------------------------------------------------
//   IDLE          | line high, waiting for a byte
//   TX_START_BIT  | driving the start bit (0)
//   TX_DATA_BITS  | driving shifter[bit_index], LSB first
//   TX_PARITY_BIT | driving the parity bit (parity builds only)
//   TX_STOP_BIT   | driving the stop bit (1); chains the next byte if any
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_ODD   = 0
) (
    input  logic      i_Clock,
    input  logic      i_Reset,
    uart_tx_if.slave  tx_bus
);

    localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1) begin : g_bad_stop
        $error("uart_tx: only one stop bit is supported");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [2:0]           bit_index;
    logic [2:0]           next_index;
    logic                 accept;
    logic                 bit_end;
    logic                 timer_clear;
    logic                 frame_end;

    assign accept      = tx_bus.i_TX_DV && !hold_full;
    assign timer_clear = (state == IDLE) && accept;
    assign frame_end   = (state == TX_STOP_BIT) && bit_end;
    assign tx_bus.o_TX_Ready = !hold_full;

    always_comb begin
        next_index = bit_index + 3'd1;
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .clear   (timer_clear),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state              <= IDLE;
            shifter            <= '0;
            hold               <= '0;
            hold_full          <= 1'b0;
            bit_index          <= '0;
            tx_bus.o_TX_Serial <= 1'b1;
            tx_bus.o_TX_Active <= 1'b0;
            tx_bus.o_TX_Done   <= 1'b0;
        end else begin
            tx_bus.o_TX_Done <= 1'b0;

            // A byte accepted mid-frame is parked, except on the final stop
            // edge with the holding register empty: then it goes straight
            // into the shifter below.
            if (accept && state != IDLE && !frame_end) begin
                hold      <= tx_bus.i_TX_Byte;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx_bus.o_TX_Serial <= 1'b1;
                    tx_bus.o_TX_Active <= 1'b0;
                    bit_index          <= '0;
                    if (accept) begin
                        shifter            <= tx_bus.i_TX_Byte;
                        state              <= TX_START_BIT;
                        tx_bus.o_TX_Serial <= 1'b0;
                        tx_bus.o_TX_Active <= 1'b1;
                    end
                end

                TX_START_BIT: begin
                    if (bit_end) begin
                        state              <= TX_DATA_BITS;
                        bit_index          <= '0;
                        tx_bus.o_TX_Serial <= shifter[0];
                    end
                end

                TX_DATA_BITS: begin
                    if (bit_end) begin
                        if (bit_index == LAST_INDEX) begin
`ifdef UART_TX_PARITY_EN
                            state              <= TX_PARITY_BIT;
                            tx_bus.o_TX_Serial <= (^shifter) ^ 1'(PARITY_ODD);
`else
                            state              <= TX_STOP_BIT;
                            tx_bus.o_TX_Serial <= 1'b1;
`endif
                        end else begin
                            bit_index          <= next_index;
                            tx_bus.o_TX_Serial <= shifter[next_index];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                TX_PARITY_BIT: begin
                    if (bit_end) begin
                        state              <= TX_STOP_BIT;
                        tx_bus.o_TX_Serial <= 1'b1;
                    end
                end
`endif

                TX_STOP_BIT: begin
                    if (bit_end) begin
                        tx_bus.o_TX_Done <= 1'b1;
                        if (hold_full) begin
                            shifter            <= hold;
                            hold_full          <= 1'b0;
                            state              <= TX_START_BIT;
                            tx_bus.o_TX_Serial <= 1'b0;
                        end else if (accept) begin
                            shifter            <= tx_bus.i_TX_Byte;
                            state              <= TX_START_BIT;
                            tx_bus.o_TX_Serial <= 1'b0;
                        end else begin
                            state              <= IDLE;
                            tx_bus.o_TX_Serial <= 1'b1;
                            tx_bus.o_TX_Active <= 1'b0;
                        end
                    end
                end

                default: begin
                    state              <= IDLE;
                    tx_bus.o_TX_Serial <= 1'b1;
                    tx_bus.o_TX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus for uart_tx, checked every
// cycle against a frame-level reference model (a frame is an array of bit
// levels, each held CLKS_PER_BIT cycles; accepted bytes wait in a one-deep
// holding slot).
module tb_uart_tx;
    import uart_pkg::*;

    localparam int C = 4;
    localparam int P = 0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * C;

    logic i_Clock = 1'b0;
    logic i_Reset;

    uart_tx_if bus();

    uart_tx #(
        .CLKS_PER_BIT (C),
        .PARITY_ODD   (P)
    ) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .tx_bus  (bus)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done_seen = 0;
    int n_done_exp  = 0;

    // reference model state
    int         m_pos = -1;     // cycles into current frame, -1 when idle
    logic [7:0] m_cur = '0;
    logic [7:0] m_hold = '0;
    bit         m_hold_full = 1'b0;
    bit         m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic frame_level(input logic [7:0] b, input int bit_no);
        if (bit_no == 0) return 1'b0;
        if (bit_no <= 8) return b[bit_no-1];
`ifdef UART_TX_PARITY_EN
        if (bit_no == 9) return (^b) ^ (P != 0);
`endif
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_pos = -1;
        m_hold_full = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_update();
        bit acc;
        bit taken;
        m_done = 1'b0;
        if (i_Reset) begin
            model_clear();
            return;
        end
        acc   = bus.i_TX_DV && !m_hold_full;
        taken = 1'b0;
        if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FRAME_LEN) begin
                m_done = 1'b1;
                n_done_exp++;
                if (m_hold_full) begin
                    m_cur = m_hold;
                    m_hold_full = 1'b0;
                    m_pos = 0;
                end else if (acc) begin
                    m_cur = bus.i_TX_Byte;
                    m_pos = 0;
                    taken = 1'b1;
                end else begin
                    m_pos = -1;
                end
            end
        end else if (acc) begin
            m_cur = bus.i_TX_Byte;
            m_pos = 0;
            taken = 1'b1;
        end
        if (acc && !taken) begin
            m_hold = bus.i_TX_Byte;
            m_hold_full = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic exp_serial;
        exp_serial = (m_pos < 0) ? 1'b1 : frame_level(m_cur, m_pos / C);
        chk("serial", bus.o_TX_Serial, exp_serial);
        chk("active", bus.o_TX_Active, m_pos >= 0);
        chk("ready",  bus.o_TX_Ready, !m_hold_full);
        chk("done",   bus.o_TX_Done, m_done);
        if (bus.o_TX_Done) n_done_seen++;
    endtask

    // one clock: model follows the rising edge, outputs compared on the falling edge
    task automatic step();
        @(posedge i_Clock);
        model_update();
        @(negedge i_Clock);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_TX_DV   = 1'b1;
        bus.i_TX_Byte = b;
        step();
        bus.i_TX_DV   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_now();
        i_Reset = 1'b1;
        #1;
        chk("rst_serial", bus.o_TX_Serial, 1'b1);
        chk("rst_active", bus.o_TX_Active, 1'b0);
        chk("rst_ready",  bus.o_TX_Ready,  1'b1);
        chk("rst_done",   bus.o_TX_Done,   1'b0);
        model_clear();
        run(2);
        @(negedge i_Clock);
        i_Reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * FRAME_LEN && m_pos >= 0; k++) step();
        chk("drain_idle", bus.o_TX_Active, 1'b0);
    endtask

    initial begin
        i_Reset       = 1'b1;
        bus.i_TX_DV   = 1'b0;
        bus.i_TX_Byte = '0;
        run(3);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        run(3);

        // single byte
        send(8'h55);
        run(FRAME_LEN + 8);

        // back to back, then an overflow attempt with the holding slot full
        send(8'hA5);
        run(4);
        send(8'h3C);
        run(3);
        send(8'hEE);
        drain();
        run(4);

        // accept on the exact final stop-bit edge with the holding slot empty
        send(8'h81);
        for (int k = 0; k < FRAME_LEN && m_pos != FRAME_LEN - 1; k++) step();
        send(8'hC3);
        drain();

        // reset mid-frame, then a clean frame
        send(8'h00);
        run(14);
        reset_now();
        run(2);
        send(8'h96);
        drain();
        run(3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.i_TX_DV   = ($urandom_range(0, 5) == 0);
            bus.i_TX_Byte = 8'($urandom);
            step();
            if (i == 900) reset_now();
        end
        bus.i_TX_DV = 1'b0;
        drain();

        chk("done_count", n_done_seen, n_done_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity by default.
- It is the transmit end of the UART link and the companion of the existing UART receiver; frames produced here must be accepted by that receiver with the same CLKS_PER_BIT.
- A one-byte holding register in front of the shifter lets a producer queue the next byte mid-frame, so consecutive frames go out with zero idle gap.

Parameters:
- CLKS_PER_BIT, 217, i_Clock cycles per serial bit (clock freq / baud); legal range >= 2.
- PARITY_ODD, 0, parity sense (0 even, 1 odd); only meaningful when UART_TX_PARITY_EN is defined.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_TX_DV  in  1  byte-valid strobe; a byte is accepted on a rising edge where i_TX_DV=1 and o_TX_Ready=1.
- i_TX_Byte  in  8  byte to send; sampled only on the accept edge.
- o_TX_Ready  out  1  holding register empty; producer may present a byte.
- o_TX_Active  out  1  frame in progress (start, data, parity or stop bit).
- o_TX_Serial  out  1  serial line; idles high.
- o_TX_Done  out  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, holding register empty.
  - o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0.
  - Bit counter=0, bit index=0.
  - Reset mid-frame aborts the frame: line goes high immediately, no o_TX_Done pulse, any held byte is discarded.
- Bit counter width: $clog2(CLKS_PER_BIT)+1. Every bit, including start, parity and stop, is driven for exactly CLKS_PER_BIT cycles.
- States: IDLE, TX_START_BIT, TX_DATA_BITS, (TX_PARITY_BIT), TX_STOP_BIT.
- IDLE:
  - o_TX_Serial=1.
  - On an accept edge N, the byte loads directly into the shifter and the state goes to TX_START_BIT.
  - o_TX_Serial=0 and o_TX_Active=1 from edge N. o_TX_Ready stays 1 because the holding register is still empty.
- TX_START_BIT: after CLKS_PER_BIT cycles, go to TX_DATA_BITS with bit index 0.
- TX_DATA_BITS:
  - Drive shifter[index] for CLKS_PER_BIT cycles, then increment the index.
  - After index 7, go to TX_STOP_BIT, or TX_PARITY_BIT when parity is enabled.
- TX_STOP_BIT: drive 1 for CLKS_PER_BIT cycles. On the final edge, o_TX_Done=1 for exactly one cycle.
  - If the holding register is full, move its byte to the shifter, mark the holding register empty, and go to TX_START_BIT (zero-gap back-to-back). o_TX_Active stays 1.
  - Else, if an accept occurs on this same edge, load i_TX_Byte directly into the shifter and go to TX_START_BIT.
  - Otherwise go to IDLE with o_TX_Active=0.
- Holding register:
  - An accept while the shifter is busy (not IDLE) writes the holding register; o_TX_Ready=0 from the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored: no state change and no overwrite.
- The default branch of the state machine returns to IDLE with the line high.
- End-to-end: frame length 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity); latency from the accept edge to the start-bit edge is 0 cycles.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - TX_PARITY_BIT state between the last data bit and stop, driven for CLKS_PER_BIT cycles.
  - Parity bit value = ^byte ^ PARITY_ODD.
  - Frame is 11 bits.
- Undefined:
  - No parity state; PARITY_ODD is unused.
  - Frame is 10 bits, compatible with the existing receiver.

Decomposition:
- Package uart_pkg:
  - State encoding constants, shared naming with the receiver's states.
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
  - Default CLKS_PER_BIT value.
- One sub-module, uart_bit_timer:
  - Counts to CLKS_PER_BIT-1 and emits a bit_end pulse.
  - Clear input used on frame start.
  - Reusable later by the receiver.
- Holding register and state machine stay in uart_tx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Single byte: accept 0x55 on an idle line -> o_TX_Serial shows 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. o_TX_Done pulses once, 40 cycles after the accept edge; o_TX_Active is high for those 40 cycles.
- Back-to-back: accept 0xA5, then 0x3C at cycle 5 -> o_TX_Ready is 0 from cycle 6 to 40. Second start bit begins at cycle 40 with no high gap; two o_TX_Done pulses, 40 cycles apart.
- Overflow: with the holding register full, pulse i_TX_DV with 0xEE -> ignored; only the two queued bytes appear on the line.
- Reset mid-frame: accept 0x00, assert i_Reset at cycle 15 -> o_TX_Serial=1 immediately. o_TX_Ready=1, o_TX_Active=0, no o_TX_Done. A new byte accepted after release transmits correctly.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): send 0x07 -> parity bit 1 for 4 cycles, frame 44 cycles. With PARITY_ODD=1, send 0x03 -> parity bit 1.
- Loopback (CLKS_PER_BIT=217): drive the existing receiver from o_TX_Serial with bytes 0x00, 0xFF, 0x81, 0x5A sent back-to-back -> receiver's valid pulses deliver identical bytes in order.
